// File: rtl/sram_bank_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM bank wrapper.
// Combinational grant (round-robin or m0-priority), one-cycle registered response routing.
module sram_bank_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            m0_req_i,
    input  logic [AW-1:0]   m0_addr_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_be_i,
    input  logic [DW-1:0]   m0_wdata_i,
    output logic            m0_gnt_o,
    output logic            m0_rvalid_o,
    output logic [DW-1:0]   m0_rdata_o,

    input  logic            m1_req_i,
    input  logic [AW-1:0]   m1_addr_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_be_i,
    input  logic [DW-1:0]   m1_wdata_i,
    output logic            m1_gnt_o,
    output logic            m1_rvalid_o,
    output logic [DW-1:0]   m1_rdata_o,

    output logic            ram_en_o,
    output logic            ram_we_o,
    output logic [DW/8-1:0] ram_be_o,
    output logic [AW-1:0]   ram_addr_o,
    output logic [DW-1:0]   ram_wdata_o,
    input  logic [DW-1:0]   ram_rdata_i,

    output logic [15:0]     conflict_cnt_o
);
    localparam int NM = 2;
    localparam int BW = DW / 8;

    logic [NM-1:0]         req, we, gnt, rvalid;
    logic [NM-1:0][AW-1:0] addr;
    logic [NM-1:0][BW-1:0] be;
    logic [NM-1:0][DW-1:0] wdata, rdata;

    logic rr_ptr;
    logic resp_valid, resp_sel, resp_we;
    logic both, win;

    assign req   = {m1_req_i,   m0_req_i};
    assign we    = {m1_we_i,    m0_we_i};
    assign addr  = {m1_addr_i,  m0_addr_i};
    assign be    = {m1_be_i,    m0_be_i};
    assign wdata = {m1_wdata_i, m0_wdata_i};
    assign both  = m0_req_i & m1_req_i;

    always_comb begin
        gnt = '0;
        if (both) begin
            if (FIXED_PRIO != 0 || !rr_ptr) gnt[0] = 1'b1;
            else                            gnt[1] = 1'b1;
        end else begin
            gnt = req;
        end
    end

    // With no grant win=0, so the bank sees m0's payload with en low.
    assign win         = gnt[1];
    assign ram_en_o    = |gnt;
    assign ram_we_o    = we[win];
    assign ram_be_o    = be[win];
    assign ram_addr_o  = addr[win];
    assign ram_wdata_o = wdata[win];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= 1'b0;
            resp_valid     <= 1'b0;
            resp_sel       <= 1'b0;
            resp_we        <= 1'b0;
            conflict_cnt_o <= '0;
        end else begin
            if (gnt[0])      rr_ptr <= 1'b1;
            else if (gnt[1]) rr_ptr <= 1'b0;

            resp_valid <= ram_en_o;
            if (ram_en_o) begin
                resp_sel <= win;
                resp_we  <= we[win];
            end

            if (both && conflict_cnt_o != 16'hFFFF)
                conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end

    // Write responses carry no data; rdata is forced to zero outside a read response.
    for (genvar i = 0; i < NM; i++) begin : g_resp
        assign rvalid[i] = resp_valid & (resp_sel == 1'(i));
        assign rdata[i]  = (rvalid[i] && !resp_we) ? ram_rdata_i : '0;
    end

    assign m0_gnt_o    = gnt[0];
    assign m1_gnt_o    = gnt[1];
    assign m0_rvalid_o = rvalid[0];
    assign m1_rvalid_o = rvalid[1];
    assign m0_rdata_o  = rdata[0];
    assign m1_rdata_o  = rdata[1];
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed bench: round-robin instance with a behavioural bank model, plus a
// fixed-priority instance sharing the same request stimulus.
module tb_sram_bank_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [3:0]    m0_be, m1_be;
    logic [31:0]   m0_wdata, m1_wdata;

    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en, ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata;
    logic [15:0]   cnt;

    logic          fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0]   fp_m0_rdata, fp_m1_rdata;
    logic          fp_ram_en, fp_ram_we;
    logic [3:0]    fp_ram_be;
    logic [AW-1:0] fp_ram_addr;
    logic [31:0]   fp_ram_wdata;
    logic [31:0]   fp_ram_rdata = 32'h0;
    logic [15:0]   fp_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bank_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .conflict_cnt_o(cnt)
    );

    sram_bank_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(fp_m0_gnt), .m0_rvalid_o(fp_m0_rvalid), .m0_rdata_o(fp_m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(fp_m1_gnt), .m1_rvalid_o(fp_m1_rvalid), .m1_rdata_o(fp_m1_rdata),
        .ram_en_o(fp_ram_en), .ram_we_o(fp_ram_we), .ram_be_o(fp_ram_be), .ram_addr_o(fp_ram_addr),
        .ram_wdata_o(fp_ram_wdata), .ram_rdata_i(fp_ram_rdata), .conflict_cnt_o(fp_cnt)
    );

    // Bank model: byte-masked writes, read data registered one cycle after en.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gc0, gc1;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = 4'hF; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = 4'hF; m1_wdata = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset in the middle of an outstanding read response
        m0_req = 1; m0_addr = 14'h5;
        #1 chk("pre_rst_gnt0", m0_gnt, 1);
        tick();
        rst_n = 1'b0;
        m0_req = 0;
        #1 chk("rst_rvalid0", m0_rvalid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_ram_en", ram_en, 0);
        chk("idle_gnt", {m1_gnt, m0_gnt}, 0);
        chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("idle_cnt", cnt, 0);
        tick();
        chk("post_rel_rvalid", {m1_rvalid, m0_rvalid}, 0);

        // Round-robin under continuous dual reads; fixed-prio instance sees the same
        m0_req = 1; m0_we = 0; m0_addr = 14'h1;
        m1_req = 1; m1_we = 0; m1_addr = 14'h2;
        gc0 = 0; gc1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_gnt0", m0_gnt, (i % 2) == 0);
            chk("rr_gnt1", m1_gnt, (i % 2) == 1);
            chk("fp_gnt", {fp_m1_gnt, fp_m0_gnt}, 2'b01);
            gc0 += int'(m0_gnt);
            gc1 += int'(m1_gnt);
            tick();
            chk("rr_rvalid0", m0_rvalid, (i % 2) == 0);
            chk("rr_rvalid1", m1_rvalid, (i % 2) == 1);
        end
        chk("rr_cnt0", gc0, 4);
        chk("rr_cnt1", gc1, 4);
        chk("conflict_cnt8", cnt, 16'd8);
        m0_req = 0;
        #1;
        chk("fp_m1_after_drop", {fp_m1_gnt, fp_m0_gnt}, 2'b10);
        m1_req = 0;
        tick();
        tick();

        // m0 write then read back
        m0_req = 1; m0_we = 1; m0_addr = 14'h0010; m0_be = 4'hF; m0_wdata = 32'hDEADBEEF;
        #1;
        chk("wr_gnt0", m0_gnt, 1);
        chk("wr_ram_en", ram_en, 1);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_addr", ram_addr, 32'h10);
        chk("wr_ram_wdata", ram_wdata, 32'hDEADBEEF);
        tick();
        m0_we = 0;
        #1;
        chk("wr_rvalid0", m0_rvalid, 1);
        chk("wr_rdata0", m0_rdata, 0);
        chk("rd_gnt0", m0_gnt, 1);
        chk("rd_ram_we", ram_we, 0);
        tick();
        m0_req = 0;
        #1;
        chk("rd_rvalid0", m0_rvalid, 1);
        chk("rd_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("rd_rvalid1", m1_rvalid, 0);
        tick();
        chk("rd_idle_rdata0", m0_rdata, 0);
        chk("rd_idle_rvalid0", m0_rvalid, 0);

        // m1 partial write over a zeroed word
        m1_req = 1; m1_we = 1; m1_addr = 14'h0020; m1_be = 4'b0101; m1_wdata = 32'h11223344;
        #1;
        chk("be_gnt1", m1_gnt, 1);
        chk("be_ram_be", ram_be, 4'b0101);
        chk("be_ram_addr", ram_addr, 32'h20);
        tick();
        m1_we = 0; m1_be = 4'hF;
        tick();
        m1_req = 0;
        #1;
        chk("be_rvalid1", m1_rvalid, 1);
        chk("be_rdata1", m1_rdata, 32'h00220044);
        chk("be_rdata0", m0_rdata, 0);
        tick();

        // Conflict counter saturation
        m0_req = 1; m1_req = 1;
        repeat (65540) @(posedge clk);
        #1 chk("cnt_sat", cnt, 16'hFFFF);
        tick();
        chk("cnt_sat_hold", cnt, 16'hFFFF);
        m0_req = 0; m1_req = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
